// File: rtl/onchip_mem_pkg.sv
// onchip_mem_pkg: shared types and constants for the two-port on-chip memory.
//   mem_state_e  : controller state (CLEAR sweep / READY for traffic)
//   RD_LAT_MIN/MAX : supported read latencies
//   lat_is_two() : selects the extra output stage from the RD_LAT parameter
package onchip_mem_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } mem_state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  // Any latency above the minimum selects the two-stage read path.
  function automatic bit lat_is_two(input int rd_lat);
    return (rd_lat >= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/onchip_mem_2p_if.sv
// onchip_mem_2p_if: bus bundle for onchip_mem_2p.
//   Host port  : mem_address/chipselect/read/write/writedata/byteenable/clken
//                in, mem_waitrequest/readdata/readdatavalid out.
//   Fetch port : fetch_address/fetch_read in, fetch_readdata/readdatavalid out.
//   Clear      : clear_req in, clear_busy out.
// master = the requester side, slave = the memory.
interface onchip_mem_2p_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);

  logic [ADDR_W-1:0]   mem_address;
  logic                mem_chipselect;
  logic                mem_read;
  logic                mem_write;
  logic [DATA_W-1:0]   mem_writedata;
  logic [DATA_W/8-1:0] mem_byteenable;
  logic                mem_clken;
  logic                mem_waitrequest;
  logic [DATA_W-1:0]   mem_readdata;
  logic                mem_readdatavalid;

  logic [ADDR_W-1:0]   fetch_address;
  logic                fetch_read;
  logic [DATA_W-1:0]   fetch_readdata;
  logic                fetch_readdatavalid;

  logic                clear_req;
  logic                clear_busy;

  modport master (
    output mem_address, mem_chipselect, mem_read, mem_write,
           mem_writedata, mem_byteenable, mem_clken,
           fetch_address, fetch_read, clear_req,
    input  mem_waitrequest, mem_readdata, mem_readdatavalid,
           fetch_readdata, fetch_readdatavalid, clear_busy
  );

  modport slave (
    input  mem_address, mem_chipselect, mem_read, mem_write,
           mem_writedata, mem_byteenable, mem_clken,
           fetch_address, fetch_read, clear_req,
    output mem_waitrequest, mem_readdata, mem_readdatavalid,
           fetch_readdata, fetch_readdatavalid, clear_busy
  );

endinterface

// File: rtl/onchip_mem_ram_2p.sv
// onchip_mem_ram_2p: simple dual-port byte-enabled RAM.
//   clk, rst          : clock; rst clears only the read output registers
//   a_addr/a_we/a_be/a_wdata/a_re -> a_rdata : write/read port
//   b_addr/b_re -> b_rdata                   : read-only port
// Reads are registered and return the contents before any same-cycle write
// (old data). Each output register holds until its port reads again.
module onchip_mem_ram_2p #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic                a_we,
  input  logic [DATA_W/8-1:0] a_be,
  input  logic [DATA_W-1:0]   a_wdata,
  input  logic                a_re,
  output logic [DATA_W-1:0]   a_rdata,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic                b_re,
  output logic [DATA_W-1:0]   b_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int BE_W  = DATA_W / 8;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] a_rdata_r;
  logic [DATA_W-1:0] b_rdata_r;

  // Byte-lane writes through port A; the array itself is never reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++) begin
      if (a_we && a_be[i]) begin
        mem_r[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
      end
    end
  end

  // Registered reads on both ports; non-blocking update gives old-data RDW.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_rdata_r <= {DATA_W{1'b0}};
      b_rdata_r <= {DATA_W{1'b0}};
    end else begin
      if (a_re) begin
        a_rdata_r <= mem_r[a_addr];
      end
      if (b_re) begin
        b_rdata_r <= mem_r[b_addr];
      end
    end
  end

  assign a_rdata = a_rdata_r;
  assign b_rdata = b_rdata_r;

endmodule

// File: rtl/onchip_mem_2p.sv
// onchip_mem_2p: two-port on-chip memory with host and instruction-fetch
// ports and a zeroing sweep.
//   clk_clk     : clock
//   reset_reset : synchronous active-high reset
//   bus         : onchip_mem_2p_if slave (host, fetch and clear signals)
// The sweep owns RAM port A while in CLEAR; the host is held off by
// mem_waitrequest, so the two never compete. The host read path advances only
// on cycles with mem_clken=1; the fetch path ignores mem_clken.
module onchip_mem_2p
  import onchip_mem_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 10,
  parameter int RD_LAT         = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic            clk_clk,
  input  logic            reset_reset,
  onchip_mem_2p_if.slave  bus
);

  localparam int                BE_W      = DATA_W / 8;
  localparam bit                LAT2      = lat_is_two(RD_LAT);
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  mem_state_e        state_r;
  logic [ADDR_W-1:0] sweep_r;

  logic              clear_busy_s;
  logic              waitreq_s;
  logic              host_acc_s;
  logic              host_wr_s;
  logic              host_rd_s;
  logic              fetch_rd_s;

  logic [ADDR_W-1:0] ram_a_addr_s;
  logic              ram_a_we_s;
  logic [BE_W-1:0]   ram_a_be_s;
  logic [DATA_W-1:0] ram_a_wdata_s;
  logic              ram_a_re_s;
  logic [DATA_W-1:0] ram_a_q_s;
  logic              ram_b_re_s;
  logic [DATA_W-1:0] ram_b_q_s;

  assign clear_busy_s = (state_r == CLEAR);
  assign waitreq_s    = clear_busy_s | ~bus.mem_clken;
  assign host_acc_s   = bus.mem_chipselect & ~waitreq_s & (bus.mem_read | bus.mem_write);
  assign host_wr_s    = host_acc_s & bus.mem_write;
  // A combined read+write is a write only.
  assign host_rd_s    = host_acc_s & bus.mem_read & ~bus.mem_write;
  assign fetch_rd_s   = bus.fetch_read & ~clear_busy_s & ~reset_reset;

  assign bus.clear_busy      = clear_busy_s;
  assign bus.mem_waitrequest = waitreq_s;

  // Port A source select: sweep writes in CLEAR, host traffic otherwise;
  // nothing touches the array while reset is asserted.
  always_comb begin
    ram_a_addr_s  = bus.mem_address;
    ram_a_we_s    = 1'b0;
    ram_a_be_s    = bus.mem_byteenable;
    ram_a_wdata_s = bus.mem_writedata;
    ram_a_re_s    = 1'b0;
    if (reset_reset) begin
      ram_a_we_s = 1'b0;
      ram_a_re_s = 1'b0;
    end else if (clear_busy_s) begin
      ram_a_addr_s  = sweep_r;
      ram_a_we_s    = 1'b1;
      ram_a_be_s    = {BE_W{1'b1}};
      ram_a_wdata_s = {DATA_W{1'b0}};
      ram_a_re_s    = 1'b0;
    end else begin
      ram_a_we_s = host_wr_s;
      ram_a_re_s = host_rd_s;
    end
  end

  assign ram_b_re_s = fetch_rd_s;

  // Controller FSM and sweep counter: one zero write per CLEAR cycle.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_r <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      sweep_r <= {ADDR_W{1'b0}};
    end else begin
      case (state_r)
        CLEAR: begin
          if (sweep_r == LAST_ADDR) begin
            state_r <= READY;
            sweep_r <= {ADDR_W{1'b0}};
          end else begin
            sweep_r <= sweep_r + ADDR_W'(1);
          end
        end
        READY: begin
          if (bus.clear_req) begin
            state_r <= CLEAR;
            sweep_r <= {ADDR_W{1'b0}};
          end else begin
            state_r <= READY;
          end
        end
        default: begin
          state_r <= READY;
          sweep_r <= {ADDR_W{1'b0}};
        end
      endcase
    end
  end

  onchip_mem_ram_2p #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk_clk),
    .rst     (reset_reset),
    .a_addr  (ram_a_addr_s),
    .a_we    (ram_a_we_s),
    .a_be    (ram_a_be_s),
    .a_wdata (ram_a_wdata_s),
    .a_re    (ram_a_re_s),
    .a_rdata (ram_a_q_s),
    .b_addr  (bus.fetch_address),
    .b_re    (ram_b_re_s),
    .b_rdata (ram_b_q_s)
  );

  if (LAT2) begin : g_lat2
    logic              host_s1_r;
    logic              host_vo_r;
    logic [DATA_W-1:0] host_do_r;
    logic              fetch_s1_r;
    logic              fetch_vo_r;
    logic [DATA_W-1:0] fetch_do_r;

    // Host second stage: frozen while clken is low, with the valid pulse
    // suppressed so each read produces exactly one valid cycle.
    always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
        host_s1_r <= 1'b0;
        host_vo_r <= 1'b0;
        host_do_r <= {DATA_W{1'b0}};
      end else if (bus.mem_clken) begin
        host_s1_r <= host_rd_s;
        host_vo_r <= host_s1_r;
        if (host_s1_r) begin
          host_do_r <= ram_a_q_s;
        end
      end else begin
        host_vo_r <= 1'b0;
      end
    end

    // Fetch second stage: free-running.
    always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
        fetch_s1_r <= 1'b0;
        fetch_vo_r <= 1'b0;
        fetch_do_r <= {DATA_W{1'b0}};
      end else begin
        fetch_s1_r <= fetch_rd_s;
        fetch_vo_r <= fetch_s1_r;
        if (fetch_s1_r) begin
          fetch_do_r <= ram_b_q_s;
        end
      end
    end

    assign bus.mem_readdatavalid   = host_vo_r;
    assign bus.mem_readdata        = host_do_r;
    assign bus.fetch_readdatavalid = fetch_vo_r;
    assign bus.fetch_readdata      = fetch_do_r;
  end else begin : g_lat1
    logic host_vo_r;
    logic fetch_vo_r;

    // Single-cycle valids; data comes straight from the RAM output register.
    always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
        host_vo_r  <= 1'b0;
        fetch_vo_r <= 1'b0;
      end else begin
        host_vo_r  <= bus.mem_clken & host_rd_s;
        fetch_vo_r <= fetch_rd_s;
      end
    end

    assign bus.mem_readdatavalid   = host_vo_r;
    assign bus.mem_readdata        = ram_a_q_s;
    assign bus.fetch_readdatavalid = fetch_vo_r;
    assign bus.fetch_readdata      = ram_b_q_s;
  end

endmodule

// File: tb/tb_onchip_mem_2p.sv
// tb_onchip_mem_2p: drives identical traffic into a RD_LAT=1 and a RD_LAT=2
// instance (ADDR_W=4, CLEAR_ON_RESET=1) and checks both against an array
// model of the memory plus latency arithmetic.
module tb_onchip_mem_2p;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [AW-1:0] t_addr;
  logic          t_cs, t_rd, t_wr, t_clken;
  logic [DW-1:0] t_wd;
  logic [3:0]    t_be;
  logic [AW-1:0] t_faddr;
  logic          t_fread;
  logic          t_creq;

  onchip_mem_2p_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();
  onchip_mem_2p_if #(.DATA_W(DW), .ADDR_W(AW)) bus2 ();

  assign bus1.mem_address    = t_addr;
  assign bus1.mem_chipselect = t_cs;
  assign bus1.mem_read       = t_rd;
  assign bus1.mem_write      = t_wr;
  assign bus1.mem_writedata  = t_wd;
  assign bus1.mem_byteenable = t_be;
  assign bus1.mem_clken      = t_clken;
  assign bus1.fetch_address  = t_faddr;
  assign bus1.fetch_read     = t_fread;
  assign bus1.clear_req      = t_creq;
  assign bus2.mem_address    = t_addr;
  assign bus2.mem_chipselect = t_cs;
  assign bus2.mem_read       = t_rd;
  assign bus2.mem_write      = t_wr;
  assign bus2.mem_writedata  = t_wd;
  assign bus2.mem_byteenable = t_be;
  assign bus2.mem_clken      = t_clken;
  assign bus2.fetch_address  = t_faddr;
  assign bus2.fetch_read     = t_fread;
  assign bus2.clear_req      = t_creq;

  onchip_mem_2p #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1), .CLEAR_ON_RESET(1)) dut1 (
    .clk_clk(clk), .reset_reset(rst), .bus(bus1));
  onchip_mem_2p #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(2), .CLEAR_ON_RESET(1)) dut2 (
    .clk_clk(clk), .reset_reset(rst), .bus(bus2));

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] mem_m [DEPTH];
  int w_cnt [2];
  int w_at  [2];
  logic [DW-1:0] w_dat [2];

  function automatic logic hv(input int d);
    return (d == 0) ? bus1.mem_readdatavalid : bus2.mem_readdatavalid;
  endfunction
  function automatic logic [DW-1:0] hd(input int d);
    return (d == 0) ? bus1.mem_readdata : bus2.mem_readdata;
  endfunction
  function automatic logic fv(input int d);
    return (d == 0) ? bus1.fetch_readdatavalid : bus2.fetch_readdatavalid;
  endfunction
  function automatic logic [DW-1:0] fd(input int d);
    return (d == 0) ? bus1.fetch_readdata : bus2.fetch_readdata;
  endfunction
  function automatic logic wq(input int d);
    return (d == 0) ? bus1.mem_waitrequest : bus2.mem_waitrequest;
  endfunction
  function automatic logic cb(input int d);
    return (d == 0) ? bus1.clear_busy : bus2.clear_busy;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
    for (int b = 0; b < 4; b++) begin
      if (be[b]) mem_m[a][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  // Observe n cycles after a request; the first `stall` of them run with clken=0.
  task automatic watch(input int n, input int stall, input bit is_fetch);
    for (int d = 0; d < 2; d++) begin
      w_cnt[d] = 0; w_at[d] = 0; w_dat[d] = '0;
    end
    for (int k = 1; k <= n; k++) begin
      t_clken = (k <= stall) ? 1'b0 : 1'b1;
      #1;
      for (int d = 0; d < 2; d++) begin
        if (k <= stall) chk($sformatf("stall waitrequest dut%0d k%0d", d, k), {31'd0, wq(d)}, 32'd1);
        if (is_fetch ? fv(d) : hv(d)) begin
          w_cnt[d]++;
          if (w_cnt[d] == 1) begin
            w_at[d]  = k;
            w_dat[d] = is_fetch ? fd(d) : hd(d);
          end
        end
      end
      step();
    end
    t_clken = 1'b1;
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
    t_addr = a; t_cs = 1'b1; t_wr = 1'b1; t_rd = 1'b0; t_wd = d; t_be = be; t_clken = 1'b1;
    #1;
    chk($sformatf("write accept a%0d", a), {31'd0, bus1.mem_waitrequest}, 32'd0);
    model_write(a, d, be);
    step();
    t_cs = 1'b0; t_wr = 1'b0;
  endtask

  task automatic host_read(input logic [AW-1:0] a, input int stall);
    logic [DW-1:0] exp;
    exp = mem_m[a];
    t_addr = a; t_cs = 1'b1; t_rd = 1'b1; t_wr = 1'b0; t_clken = 1'b1;
    #1;
    chk($sformatf("read accept a%0d", a), {31'd0, bus2.mem_waitrequest}, 32'd0);
    step();
    t_cs = 1'b0; t_rd = 1'b0;
    watch(stall + 4, stall, 1'b0);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rd a%0d dut%0d valid count", a, d), w_cnt[d], 32'd1);
      chk($sformatf("rd a%0d dut%0d latency", a, d), w_at[d], (d == 0) ? 32'd1 : 32'(2 + stall));
      chk($sformatf("rd a%0d dut%0d data", a, d), w_dat[d], exp);
      chk($sformatf("rd a%0d dut%0d hold", a, d), hd(d), exp);
    end
  endtask

  task automatic host_rw(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
    t_addr = a; t_cs = 1'b1; t_wr = 1'b1; t_rd = 1'b1; t_wd = d; t_be = be; t_clken = 1'b1;
    #1;
    model_write(a, d, be);
    step();
    t_cs = 1'b0; t_wr = 1'b0; t_rd = 1'b0;
    watch(4, 0, 1'b0);
    for (int k = 0; k < 2; k++) chk($sformatf("rw a%0d dut%0d no valid", a, k), w_cnt[k], 32'd0);
  endtask

  task automatic fetch_read(input logic [AW-1:0] a, input bit with_wr, input logic [DW-1:0] d,
                            input logic [3:0] be);
    logic [DW-1:0] exp;
    exp = mem_m[a];
    t_faddr = a; t_fread = 1'b1;
    if (with_wr) begin
      t_addr = a; t_cs = 1'b1; t_wr = 1'b1; t_rd = 1'b0; t_wd = d; t_be = be;
      model_write(a, d, be);
    end
    step();
    t_fread = 1'b0; t_cs = 1'b0; t_wr = 1'b0;
    watch(4, 0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("fetch a%0d dut%0d valid count", a, k), w_cnt[k], 32'd1);
      chk($sformatf("fetch a%0d dut%0d latency", a, k), w_at[k], 32'(k + 1));
      chk($sformatf("fetch a%0d dut%0d data", a, k), w_dat[k], exp);
    end
  endtask

  // Count CLEAR cycles from now until both instances are READY.
  task automatic count_busy(input string tag);
    int busy [2];
    int wbad;
    busy[0] = 0; busy[1] = 0; wbad = 0;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (!cb(0) && !cb(1)) break;
      for (int d = 0; d < 2; d++) begin
        if (cb(d)) begin
          busy[d]++;
          if (!wq(d)) wbad++;
        end
      end
      step();
    end
    for (int d = 0; d < 2; d++) chk($sformatf("%s dut%0d busy cycles", tag, d), busy[d], 32'd16);
    chk($sformatf("%s waitrequest low while busy", tag), wbad, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s dut%0d readdatavalid", tag, d), {31'd0, hv(d)}, 32'd0);
      chk($sformatf("%s dut%0d readdata", tag, d), hd(d), 32'd0);
      chk($sformatf("%s dut%0d fetch valid", tag, d), {31'd0, fv(d)}, 32'd0);
      chk($sformatf("%s dut%0d fetch data", tag, d), fd(d), 32'd0);
      chk($sformatf("%s dut%0d clear_busy", tag, d), {31'd0, cb(d)}, 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "simulation time limit exceeded");
  end

  initial begin
    int fcnt [2];
    logic [DW-1:0] fdat [2];
    logic [DW-1:0] exp;
    int post;
    bit done;

    rst = 1'b1; t_addr = '0; t_cs = 1'b0; t_rd = 1'b0; t_wr = 1'b0; t_wd = '0; t_be = '0;
    t_clken = 1'b1; t_faddr = '0; t_fread = 1'b0; t_creq = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;

    // Power-on reset followed by the automatic zeroing sweep.
    step(); step(); step();
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    count_busy("power-on clear");
    for (int a = 0; a < DEPTH; a++) host_read(AW'(a), 0);

    // Byte-lane merge, byteenable=0 no-op, read+write is write-only.
    host_write(4'd5, 32'hFFFF_FFFF, 4'b1111);
    host_write(4'd5, 32'hDEAD_BEEF, 4'b0101);
    chk("model merge 0xFFADFFEF", mem_m[5], 32'hFFAD_FFEF);
    host_read(4'd5, 0);
    host_write(4'd5, $urandom, 4'b0000);
    host_read(4'd5, 0);
    host_rw(4'd8, 32'h0BAD_CAFE, 4'b1111);
    host_read(4'd8, 0);

    // Fetch during a same-address host write sees old data, then new data.
    host_write(4'd3, 32'h2222_2222, 4'b1111);
    fetch_read(4'd3, 1'b1, 32'h1111_1111, 4'b1111);
    fetch_read(4'd3, 1'b0, '0, '0);

    // Host read with a three-cycle clken stall.
    host_write(4'd10, 32'h1234_5678, 4'b1111);
    host_read(4'd10, 3);

    // Randomised mixed traffic.
    for (int i = 0; i < 120; i++) begin
      logic [AW-1:0] a;
      a = AW'($urandom_range(0, DEPTH - 1));
      case ($urandom_range(0, 4))
        0: host_write(a, $urandom, 4'($urandom_range(0, 15)));
        1: host_read(a, $urandom_range(0, 2));
        2: fetch_read(a, 1'b0, '0, '0);
        3: fetch_read(a, 1'b1, $urandom, 4'($urandom_range(0, 15)));
        default: host_rw(a, $urandom, 4'($urandom_range(0, 15)));
      endcase
    end

    // clear_req with a fetch in flight; fetches during CLEAR are dropped and
    // a second clear_req mid-sweep is ignored.
    host_write(4'd6, 32'hCAFE_F00D, 4'b1111);
    exp = mem_m[6];
    t_faddr = 4'd6; t_fread = 1'b1; t_creq = 1'b1;
    step();
    t_creq = 1'b0;
    fcnt[0] = 0; fcnt[1] = 0; fdat[0] = '0; fdat[1] = '0;
    post = 0; done = 1'b0;
    begin
      int busy [2];
      busy[0] = 0; busy[1] = 0;
      for (int k = 1; k < 60; k++) begin
        t_creq = (k == 5) ? 1'b1 : 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
          if (cb(d)) busy[d]++;
          if (fv(d)) begin
            fcnt[d]++;
            fdat[d] = fd(d);
          end
        end
        if (!done && !cb(0) && !cb(1)) begin
          done = 1'b1;
          t_fread = 1'b0;
        end
        if (done) post++;
        if (post > 3) break;
        step();
      end
      t_creq = 1'b0;
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("clear_req dut%0d busy cycles", d), busy[d], 32'd16);
        chk($sformatf("clear_req dut%0d fetch valids", d), fcnt[d], 32'd1);
        chk($sformatf("clear_req dut%0d in-flight data", d), fdat[d], exp);
      end
    end
    step();
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    for (int a = 0; a < DEPTH; a++) fetch_read(AW'(a), 1'b0, '0, '0);

    // Reset at sweep address 7 restarts the sweep and clears read outputs.
    host_write(4'd9, 32'hA5A5_5A5A, 4'b1111);
    host_read(4'd9, 0);
    fetch_read(4'd9, 1'b0, '0, '0);
    t_creq = 1'b1;
    step();
    t_creq = 1'b0;
    for (int k = 0; k < 7; k++) step();
    #1;
    chk("busy at sweep 7", {31'd0, bus2.clear_busy}, 32'd1);
    rst = 1'b1;
    step();
    #1;
    check_reset_outputs("mid-sweep reset");
    rst = 1'b0;
    count_busy("restarted clear");
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    for (int a = 0; a < DEPTH; a++) host_read(AW'(a), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/onchip_mem_2p.md
ONCHIP_MEM_2P -- requirements
Module: onchip_mem_2p

Interface
REQ-001 The block SHALL have exactly one clock, clk_clk, and reset_reset, which SHALL be synchronous and active-high.
REQ-002 Parameters (name, default, meaning), which SHALL be:
- DATA_W, 32: word width; SHALL be a multiple of 8.
- ADDR_W, 10: word address width; depth is 2**ADDR_W.
- RD_LAT, 1: read latency in cycles; SHALL be 1 or 2.
- CLEAR_ON_RESET, 1: when 1, memory is zeroed after reset.
REQ-003 Ports (name, direction, width, meaning), which SHALL be:
- clk_clk, in, 1: clock.
- reset_reset, in, 1: synchronous active-high reset.
- mem_address, in, ADDR_W: host word address.
- mem_chipselect, in, 1: host select.
- mem_read, in, 1: host read request.
- mem_write, in, 1: host write request.
- mem_writedata, in, DATA_W: host write data.
- mem_byteenable, in, DATA_W/8: host write byte lanes.
- mem_clken, in, 1: host port clock enable; low stalls the host port.
- mem_waitrequest, out, 1: host access not accepted this cycle.
- mem_readdata, out, DATA_W: host read data.
- mem_readdatavalid, out, 1: mem_readdata valid this cycle.
- fetch_address, in, ADDR_W: instruction fetch word address.
- fetch_read, in, 1: fetch request.
- fetch_readdata, out, DATA_W: fetch data.
- fetch_readdatavalid, out, 1: fetch_readdata valid this cycle.
- clear_req, in, 1: request memory zeroing.
- clear_busy, out, 1: clear sweep in progress.

Function
REQ-004 The FSM SHALL have exactly two states, CLEAR and READY.
REQ-005 Reset SHALL enter CLEAR if CLEAR_ON_RESET=1, else READY.
REQ-006 In CLEAR, the block SHALL write zero to one address per cycle, ascending from 0 to 2**ADDR_W-1, then enter READY on the cycle after the last write.
REQ-007 In READY, clear_req=1 SHALL enter CLEAR with the sweep counter at 0; clear_req SHALL be ignored while in CLEAR.
REQ-008 clear_busy SHALL equal (state==CLEAR).
REQ-009 mem_waitrequest SHALL equal clear_busy OR NOT mem_clken.
REQ-010 A host access is accepted when mem_chipselect=1, mem_waitrequest=0 and mem_read or mem_write is 1.
REQ-011 An accepted write SHALL update only the byte lanes whose mem_byteenable bit is 1; byteenable=0 is a no-op.
REQ-012 If mem_read and mem_write are both 1, the access SHALL be treated as a write only, and no readdatavalid SHALL be produced.
REQ-013 A read accepted in cycle N SHALL assert mem_readdatavalid for exactly one cycle, in cycle N+RD_LAT; mem_readdata SHALL hold its value until the next valid.
REQ-014 While mem_clken=0, the host read pipeline SHALL freeze: there SHALL be no advance, no new valid, and readdata SHALL hold; it resumes where it stopped when mem_clken returns to 1.
REQ-015 The fetch port SHALL be independent of mem_clken.
- A fetch_read in cycle N in READY SHALL give fetch_readdatavalid in cycle N+RD_LAT.
- fetch_read in CLEAR SHALL be dropped, with no valid produced.
REQ-016 Read-during-write to the same address, on either port, SHALL return the old data.
REQ-017 Reads already in flight when CLEAR is entered SHALL still complete with their pre-clear data.

Reset
REQ-018 On reset, the following SHALL be 0: mem_readdatavalid, fetch_readdatavalid, mem_readdata, fetch_readdata, the read pipelines and the sweep counter.
REQ-019 clear_busy SHALL be 1 in the first cycle after reset iff CLEAR_ON_RESET=1.
REQ-020 Reset asserted mid-sweep SHALL restart the sweep from address 0 (CLEAR_ON_RESET=1) or abandon it (CLEAR_ON_RESET=0).
REQ-021 Memory contents SHALL NOT be otherwise altered by reset.

Structure
REQ-022 A shared package onchip_mem_pkg SHALL hold:
- the FSM state enum (CLEAR, READY);
- constants RD_LAT_MIN=1 and RD_LAT_MAX=2.
REQ-023 The storage SHALL be a sub-module onchip_mem_ram_2p: a simple dual-port byte-enabled RAM with one write/read port and one read port, old-data read-during-write, and registered output.
REQ-024 The latency-2 stage, the FSM, the sweep counter and the clken stall logic SHALL reside in onchip_mem_2p.

Verification
REQ-025 Scenario: reset with CLEAR_ON_RESET=1, ADDR_W=4 -> clear_busy=1 for 16 cycles, waitrequest=1 throughout, then all 16 host reads return 0x00000000.
REQ-026 Scenario: write 0xDEADBEEF to addr 5 with byteenable=4'b0101, after 0xFFFFFFFF was stored there -> read of addr 5 returns 0xFFADFFEF, with readdatavalid exactly RD_LAT cycles after acceptance, for RD_LAT=1 and RD_LAT=2.
REQ-027 Scenario: in the same cycle, a host write of 0x11111111 to addr 3 and a fetch read of addr 3, old value 0x22222222 -> fetch returns 0x22222222; the next fetch returns 0x11111111.
REQ-028 Scenario: host read issued, then mem_clken=0 for 3 cycles at RD_LAT=2 -> valid delayed by exactly 3 cycles, data correct, waitrequest=1 during the stall.
REQ-029 Scenario: clear_req pulsed in READY while a fetch is in flight -> the in-flight fetch returns old data, fetch_read during CLEAR produces no valid, and the memory is all zero afterward.
REQ-030 Scenario: reset asserted at sweep address 7 -> the sweep restarts at 0 and completes a full 2**ADDR_W cycles.
